// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP controller: word type, layer sizes,
// parameter address map and the sequencer state encoding.
package mlp_pkg;

    localparam int NBits = 16;
    typedef logic [NBits-1:0] word_t;

    localparam int NIn  = 6;
    localparam int NHid = 16;
    localparam int NOut = 3;

    localparam int W1Base   = 0;
    localparam int B1Base   = 96;
    localparam int W2Base   = 112;
    localparam int B2Base   = 160;
    localparam int NumWords = 163;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/mlp_ctrl_if.sv
// Host-side bus of the MLP controller: config write port plus the input and
// output valid/ready handshakes. The host is master, the controller is slave.
interface mlp_ctrl_if
    import mlp_pkg::*;
();

    logic                 cfg_we_i;
    logic [7:0]           cfg_addr_i;
    word_t                cfg_wdata_i;
    logic                 cfg_err_o;

    logic                 in_valid_i;
    logic                 in_ready_o;
    word_t [NIn-1:0]      in_data_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    word_t [NOut-1:0]     out_data_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_wdata_i, in_valid_i, in_data_i, out_ready_i,
        input  cfg_err_o, in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i, in_valid_i, in_data_i, out_ready_i,
        output cfg_err_o, in_ready_o, out_valid_o, out_data_o
    );

endinterface

// File: rtl/mlp_param_regs.sv
// Weight/bias register file with its address decoder. The write enable arrives
// already qualified by the sequencer; addr_valid flags addresses inside the map.
module mlp_param_regs
    import mlp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [7:0]                  addr,
    input  word_t                       wdata,
    output logic                        addr_valid,
    output word_t [NIn-1:0][NHid-1:0]   w1,
    output word_t [NHid-1:0]            b1,
    output word_t [NHid-1:0][NOut-1:0]  w2,
    output word_t [NOut-1:0]            b2
);

    assign addr_valid = (addr < 8'(NumWords));

    // Each word owns one address; out-of-map addresses simply match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1 <= '0;
            b1 <= '0;
            w2 <= '0;
            b2 <= '0;
        end else if (we) begin
            for (int i = 0; i < NIn; i++) begin
                for (int j = 0; j < NHid; j++) begin
                    if (addr == 8'(W1Base + i * NHid + j)) w1[i][j] <= wdata;
                end
            end
            for (int j = 0; j < NHid; j++) begin
                if (addr == 8'(B1Base + j)) b1[j] <= wdata;
            end
            for (int j = 0; j < NHid; j++) begin
                for (int k = 0; k < NOut; k++) begin
                    if (addr == 8'(W2Base + j * NOut + k)) w2[j][k] <= wdata;
                end
            end
            for (int k = 0; k < NOut; k++) begin
                if (addr == 8'(B2Base + k)) b2[k] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mlp_ctrl.sv
// Sequencer for the combinational 6-16-3 MLP datapath: holds the input vector for
// SettleCycles, then captures the result. Optional MLP_CTRL_PERF_EN adds an inference counter.
module mlp_ctrl
    import mlp_pkg::*;
#(
    parameter int SettleCycles = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    mlp_ctrl_if.slave                   bus,
    output word_t [NIn-1:0]             dp_din_o,
    output word_t [NIn-1:0][NHid-1:0]   dp_w1_o,
    output word_t [NHid-1:0]            dp_b1_o,
    output word_t [NHid-1:0][NOut-1:0]  dp_w2_o,
    output word_t [NOut-1:0]            dp_b2_o,
    input  word_t [NOut-1:0]            dp_dout_i,
    output logic [31:0]                 perf_count_o
);

    if (SettleCycles < 1 || SettleCycles > 15) begin : g_bad_settle
        $error("mlp_ctrl: SettleCycles must be in 1..15");
    end

    ctrl_state_e       state;
    logic [3:0]        settle_cnt;
    word_t [NIn-1:0]   din;
    word_t [NOut-1:0]  out_data;
    logic              out_valid;
    logic              cfg_err;
    logic              addr_valid;
    logic              param_we;

    // Parameters only change while idle, so the datapath never sees a weight move mid-settle.
    assign param_we = bus.cfg_we_i && (state == IDLE);

    mlp_param_regs u_regs (
        .clk        (clk_i),
        .rst        (rst_i),
        .we         (param_we),
        .addr       (bus.cfg_addr_i),
        .wdata      (bus.cfg_wdata_i),
        .addr_valid (addr_valid),
        .w1         (dp_w1_o),
        .b1         (dp_b1_o),
        .w2         (dp_w2_o),
        .b2         (dp_b2_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            settle_cnt <= '0;
            din        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= bus.cfg_we_i && !(param_we && addr_valid);
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        din        <= bus.in_data_i;
                        settle_cnt <= 4'(SettleCycles - 1);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        out_data  <= dp_dout_i;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.cfg_err_o   = cfg_err;
    assign dp_din_o        = din;

`ifdef MLP_CTRL_PERF_EN
    logic [31:0] perf_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_count <= '0;
        end else if (out_valid && bus.out_ready_i && (perf_count != '1)) begin
            perf_count <= perf_count + 32'd1;
        end
    end

    assign perf_count_o = perf_count;
`else
    assign perf_count_o = '0;
`endif

endmodule

// File: tb/tb_mlp_ctrl.sv
// Self-checking bench for mlp_ctrl: a transaction-level model of the controller
// compared every cycle, plus directed vectors with hand-computed expectations.
module tb_mlp_ctrl;
    import mlp_pkg::*;

    localparam int S = 2;
`ifdef MLP_CTRL_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk;
    logic rst;
    mlp_ctrl_if bus ();

    word_t [NIn-1:0]             dp_din;
    word_t [NIn-1:0][NHid-1:0]   dp_w1;
    word_t [NHid-1:0]            dp_b1;
    word_t [NHid-1:0][NOut-1:0]  dp_w2;
    word_t [NOut-1:0]            dp_b2;
    word_t [NOut-1:0]            dp_dout;
    logic [31:0]                 perf;

    int vectors = 0;
    int miscompares = 0;

    mlp_ctrl #(.SettleCycles(S)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .dp_din_o     (dp_din),
        .dp_w1_o      (dp_w1),
        .dp_b1_o      (dp_b1),
        .dp_w2_o      (dp_w2),
        .dp_b2_o      (dp_b2),
        .dp_dout_i    (dp_dout),
        .perf_count_o (perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in datapath: output k is input k plus layer-2 bias k.
    always_comb begin
        dp_dout = '0;
        for (int k = 0; k < NOut; k++) dp_dout[k] = dp_din[k] + dp_b2[k];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: a flat parameter memory and an in-flight age counter.
    word_t            mem [NumWords];
    bit               m_busy;
    int               m_age;
    word_t [NIn-1:0]  m_din;
    word_t [NOut-1:0] m_out;
    bit               m_err;
    logic [31:0]      m_perf;

    always @(posedge clk or posedge rst) begin : model
        bit valid_now;
        if (rst) begin
            for (int a = 0; a < NumWords; a++) mem[a] = '0;
            m_busy = 0;
            m_age  = 0;
            m_din  = '0;
            m_out  = '0;
            m_err  = 0;
            m_perf = '0;
        end else begin
            valid_now = m_busy && (m_age == S);
            m_err = bus.cfg_we_i && (m_busy || (int'(bus.cfg_addr_i) >= NumWords));
            if (bus.cfg_we_i && !m_err) mem[bus.cfg_addr_i] = bus.cfg_wdata_i;
            if (valid_now) begin
                if (bus.out_ready_i) begin
                    m_busy = 0;
                    if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
                end
            end else if (m_busy) begin
                m_age++;
                if (m_age == S)
                    for (int k = 0; k < NOut; k++) m_out[k] = m_din[k] + mem[B2Base + k];
            end else if (bus.in_valid_i) begin
                m_busy = 1;
                m_age  = 0;
                m_din  = bus.in_data_i;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_output("in_ready", 32'(bus.in_ready_o), 32'(!m_busy));
            check_output("out_valid", 32'(bus.out_valid_o), 32'(m_busy && m_age == S));
            check_output("cfg_err", 32'(bus.cfg_err_o), 32'(m_err));
            check_output("perf", perf, PerfEn ? m_perf : 32'd0);
            for (int i = 0; i < NIn; i++) check_output("din", 32'(dp_din[i]), 32'(m_din[i]));
            for (int k = 0; k < NOut; k++) check_output("out_data", 32'(bus.out_data_o[k]), 32'(m_out[k]));
            for (int i = 0; i < NIn; i++)
                for (int j = 0; j < NHid; j++)
                    check_output("w1", 32'(dp_w1[i][j]), 32'(mem[W1Base + i * NHid + j]));
            for (int j = 0; j < NHid; j++) check_output("b1", 32'(dp_b1[j]), 32'(mem[B1Base + j]));
            for (int j = 0; j < NHid; j++)
                for (int k = 0; k < NOut; k++)
                    check_output("w2", 32'(dp_w2[j][k]), 32'(mem[W2Base + j * NOut + k]));
            for (int k = 0; k < NOut; k++) check_output("b2", 32'(dp_b2[k]), 32'(mem[B2Base + k]));
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input word_t data);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = addr;
        bus.cfg_wdata_i = data;
        next_cycle();
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic apply_stimulus(input word_t [NIn-1:0] d);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        next_cycle();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_out_valid(input int max_cycles);
        int n = 0;
        while (!bus.out_valid_o && n < max_cycles) begin
            next_cycle();
            n++;
        end
        check_output("out_valid_timeout", 32'(bus.out_valid_o), 32'd1);
    endtask

    task automatic drain_output();
        bus.out_ready_i = 1'b1;
        next_cycle();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_addr_i  = '0;
        bus.cfg_wdata_i = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
        check_output("reset_in_ready", 32'(bus.in_ready_o), 32'd1);
        check_output("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_output("reset_perf", perf, 32'd0);

        // Writes land one edge later; reset wipes them.
        cfg_write(8'd0, 16'h0100);
        check_output("w1_0_0", 32'(dp_w1[0][0]), 32'h0100);
        cfg_write(8'd162, 16'h0005);
        check_output("b2_2", 32'(dp_b2[2]), 32'h0005);
        cfg_write(8'd159, 16'h0ABC);
        check_output("w2_15_2", 32'(dp_w2[15][2]), 32'h0ABC);
        cfg_write(8'd111, 16'h7777);
        check_output("b1_15", 32'(dp_b1[15]), 32'h7777);
        pulse_reset();
        check_output("w1_0_0_rst", 32'(dp_w1[0][0]), 32'h0000);
        check_output("b2_2_rst", 32'(dp_b2[2]), 32'h0000);

        // Latency: handshake edge, two settle cycles, then valid.
        apply_stimulus({16'h00A5, 16'h00A4, 16'h00A3, 16'h0003, 16'h0002, 16'h0001});
        check_output("lat_c1_ready", 32'(bus.in_ready_o), 32'd0);
        check_output("lat_c1_valid", 32'(bus.out_valid_o), 32'd0);
        next_cycle();
        check_output("lat_c2_ready", 32'(bus.in_ready_o), 32'd0);
        check_output("lat_c2_valid", 32'(bus.out_valid_o), 32'd0);
        next_cycle();
        check_output("lat_c3_ready", 32'(bus.in_ready_o), 32'd0);
        check_output("lat_c3_valid", 32'(bus.out_valid_o), 32'd1);
        check_output("lat_out0", 32'(bus.out_data_o[0]), 32'd1);
        check_output("lat_out1", 32'(bus.out_data_o[1]), 32'd2);
        check_output("lat_out2", 32'(bus.out_data_o[2]), 32'd3);

        // Consumer stalls while a new input is offered; nothing may move.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = {16'h0F05, 16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00};
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            check_output("stall_valid", 32'(bus.out_valid_o), 32'd1);
            check_output("stall_ready", 32'(bus.in_ready_o), 32'd0);
            check_output("stall_out0", 32'(bus.out_data_o[0]), 32'd1);
            check_output("stall_din0", 32'(dp_din[0]), 32'd1);
        end
        bus.in_valid_i = 1'b0;
        drain_output();
        check_output("drain_valid", 32'(bus.out_valid_o), 32'd0);
        check_output("drain_ready", 32'(bus.in_ready_o), 32'd1);
        check_output("drain_keep", 32'(bus.out_data_o[2]), 32'd3);

        // Rejected writes: out-of-map address while idle, legal address while busy.
        cfg_write(8'd163, 16'hFFFF);
        check_output("err_invalid", 32'(bus.cfg_err_o), 32'd1);
        next_cycle();
        check_output("err_clear", 32'(bus.cfg_err_o), 32'd0);
        apply_stimulus({16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        cfg_write(8'd5, 16'h1234);
        check_output("err_settle", 32'(bus.cfg_err_o), 32'd1);
        check_output("w1_0_5_kept", 32'(dp_w1[0][5]), 32'd0);
        wait_out_valid(10);
        drain_output();

        // Reset in the middle of a settle window.
        cfg_write(8'd0, 16'h0100);
        apply_stimulus({16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        pulse_reset();
        check_output("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);
        check_output("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check_output("mid_rst_w1", 32'(dp_w1[0][0]), 32'd0);

        // Three inferences; the first overlaps a B2[0] write with its handshake.
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 8'd160;
        bus.cfg_wdata_i = 16'h0010;
        apply_stimulus({16'd0, 16'd0, 16'd0, 16'd3, 16'd2, 16'd1});
        bus.cfg_we_i = 1'b0;
        check_output("ovl_err", 32'(bus.cfg_err_o), 32'd0);
        wait_out_valid(10);
        check_output("ovl_out0", 32'(bus.out_data_o[0]), 32'h0011);
        drain_output();
        apply_stimulus({16'd0, 16'd0, 16'd0, 16'hFFFF, 16'h8000, 16'hFFF0});
        wait_out_valid(10);
        check_output("wrap_out0", 32'(bus.out_data_o[0]), 32'h0000);
        drain_output();
        apply_stimulus({16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9});
        wait_out_valid(10);
        drain_output();
        check_output("perf_three", perf, PerfEn ? 32'd3 : 32'd0);

        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
